// File: rtl/acumulador_mascara.sv
`default_nettype none
// ============================================================================
// Module   : acumulador_mascara
// Brief    : Multiply-accumulate over one NxN mask window. Unsigned pixels are
//            multiplied by signed coefficients and summed. The sum is then
//            arithmetically right-shifted, clamped to the pixel range and
//            delivered with a one-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module acumulador_mascara #(
    parameter int BITS_PIXEL          = 8,
    parameter int BITS_COEFICIENTE    = 8,
    parameter int BITS_MASCARA        = 4,
    parameter int BITS_INDICE_MASCARA = 10,
    parameter int BITS_DESPLAZAMIENTO = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inicio,
    input  logic [BITS_MASCARA-1:0]        tamano_mascara,
    input  logic [BITS_DESPLAZAMIENTO-1:0] desplazamiento,
    input  logic                           dato_valido,
    input  logic [BITS_PIXEL-1:0]          pixel,
    input  logic [BITS_COEFICIENTE-1:0]    coeficiente,
    output logic [BITS_INDICE_MASCARA-1:0] indice_mascara,
    output logic                           ocupado,
    output logic [BITS_PIXEL-1:0]          resultado,
    output logic                           resultado_valido,
    output logic                           error_tamano
);

    // Accumulator width covers (2^BITS_MASCARA-1)^2 full-scale products.
    localparam int c_BITS_PROD  = BITS_PIXEL + BITS_COEFICIENTE + 1;
    localparam int c_BITS_ACC   = c_BITS_PROD + 2 * BITS_MASCARA;
    localparam int c_BITS_TOTAL = 2 * BITS_MASCARA;

    localparam logic [1:0] c_REPOSO    = 2'd0;
    localparam logic [1:0] c_ACUMULA   = 2'd1;
    localparam logic [1:0] c_NORMALIZA = 2'd2;
    localparam logic [1:0] c_ENTREGA   = 2'd3;

    localparam logic [BITS_INDICE_MASCARA-1:0] c_UNO_INDICE = BITS_INDICE_MASCARA'(1);
    localparam logic [c_BITS_TOTAL-1:0]        c_UNO_TOTAL  = c_BITS_TOTAL'(1);

    logic [1:0]                           r_estado;
    logic [1:0]                           w_estado_sig;
    logic [BITS_MASCARA-1:0]              r_tamano;
    logic [BITS_DESPLAZAMIENTO-1:0]       r_desplazamiento;
    logic signed [c_BITS_ACC-1:0]         r_acc;
    logic [BITS_INDICE_MASCARA-1:0]       r_indice;
    logic [BITS_PIXEL-1:0]                r_resultado;
    logic                                 r_resultado_valido;
    logic                                 r_error_tamano;
    logic                                 r_ocupado;

    logic                                 w_inicio_ok;
    logic                                 w_inicio_err;
    logic                                 w_muestra;
    logic                                 w_ultima;
    logic [c_BITS_TOTAL-1:0]              w_total;
    logic [c_BITS_TOTAL-1:0]              w_ultimo_ancho;
    logic [BITS_INDICE_MASCARA-1:0]       w_ultimo_indice;
    logic [c_BITS_PROD-1:0]               w_pixel_ext;
    logic [c_BITS_PROD-1:0]               w_coef_ext;
    logic [c_BITS_PROD-1:0]               w_producto;
    logic signed [c_BITS_ACC-1:0]         w_producto_acc;
    logic signed [c_BITS_ACC-1:0]         w_desplazado;
    logic [BITS_PIXEL-1:0]                w_normalizado;

    // Start is only honoured while idle; a zero-size mask is rejected.
    assign w_inicio_ok  = (r_estado == c_REPOSO) && inicio && (tamano_mascara != '0);
    assign w_inicio_err = (r_estado == c_REPOSO) && inicio && (tamano_mascara == '0);
    assign w_muestra    = (r_estado == c_ACUMULA) && dato_valido;

    // Index of the last element is N*N-1 from the latched side length.
    assign w_total         = {{BITS_MASCARA{1'b0}}, r_tamano} * {{BITS_MASCARA{1'b0}}, r_tamano};
    assign w_ultimo_ancho  = w_total - c_UNO_TOTAL;
    assign w_ultimo_indice = BITS_INDICE_MASCARA'(w_ultimo_ancho);
    assign w_ultima        = w_muestra && (r_indice == w_ultimo_indice);

    // The product magnitude always fits c_BITS_PROD signed bits, so a
    // same-width multiply of zero/sign-extended operands is exact.
    assign w_pixel_ext    = {{(BITS_COEFICIENTE + 1){1'b0}}, pixel};
    assign w_coef_ext     = {{(BITS_PIXEL + 1){coeficiente[BITS_COEFICIENTE-1]}}, coeficiente};
    assign w_producto     = w_pixel_ext * w_coef_ext;
    assign w_producto_acc = {{(2 * BITS_MASCARA){w_producto[c_BITS_PROD-1]}}, w_producto};

    assign w_desplazado = r_acc >>> r_desplazamiento;

    // Clamp the shifted sum into the unsigned pixel range.
    always_comb begin
        w_normalizado = '0;
        if (w_desplazado[c_BITS_ACC-1]) begin
            w_normalizado = '0;
        end else if (|w_desplazado[c_BITS_ACC-2:BITS_PIXEL]) begin
            w_normalizado = '1;
        end else begin
            w_normalizado = w_desplazado[BITS_PIXEL-1:0];
        end
    end

    // Next-state logic for the window sequencer.
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            c_REPOSO:    if (w_inicio_ok) w_estado_sig = c_ACUMULA;
            c_ACUMULA:   if (w_ultima)    w_estado_sig = c_NORMALIZA;
            c_NORMALIZA: w_estado_sig = c_ENTREGA;
            c_ENTREGA:   w_estado_sig = c_REPOSO;
            default:     w_estado_sig = c_REPOSO;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= c_REPOSO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Datapath: window setup, accumulation, normalisation and flag pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tamano           <= '0;
            r_desplazamiento   <= '0;
            r_acc              <= '0;
            r_indice           <= '0;
            r_resultado        <= '0;
            r_resultado_valido <= 1'b0;
            r_error_tamano     <= 1'b0;
            r_ocupado          <= 1'b0;
        end else begin
            if (w_inicio_ok) begin
                r_tamano         <= tamano_mascara;
                r_desplazamiento <= desplazamiento;
                r_acc            <= '0;
                r_indice         <= '0;
            end
            if (w_muestra) begin
                r_acc    <= r_acc + w_producto_acc;
                r_indice <= w_ultima ? '0 : r_indice + c_UNO_INDICE;
            end
            if (r_estado == c_NORMALIZA) begin
                r_resultado <= w_normalizado;
            end
            // The valid pulse is registered out of ENTREGA, so busy is
            // stretched one cycle past ENTREGA to cover the pulse.
            r_resultado_valido <= (r_estado == c_ENTREGA);
            r_error_tamano     <= w_inicio_err;
            r_ocupado          <= (w_estado_sig != c_REPOSO) || (r_estado == c_ENTREGA);
        end
    end

    assign indice_mascara   = r_indice;
    assign ocupado          = r_ocupado;
    assign resultado        = r_resultado;
    assign resultado_valido = r_resultado_valido;
    assign error_tamano     = r_error_tamano;

endmodule
`default_nettype wire

// File: tb/tb_acumulador_mascara.sv
`default_nettype none
// ============================================================================
// Module   : tb_acumulador_mascara
// Brief    : Directed, table-driven bench for acumulador_mascara.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acumulador_mascara;

    logic       clk;
    logic       reset;
    logic       inicio;
    logic [3:0] tamano_mascara;
    logic [3:0] desplazamiento;
    logic       dato_valido;
    logic [7:0] pixel;
    logic [7:0] coeficiente;
    logic [9:0] indice_mascara;
    logic       ocupado;
    logic [7:0] resultado;
    logic       resultado_valido;
    logic       error_tamano;

    int n_cmp;
    int n_err;
    int pixs[225];
    int coefs[225];

    typedef struct {
        int n;
        int sh;
        int pix;
        int coef;
        int exp;
    } vec_t;

    vec_t tabla[14];

    acumulador_mascara dut (
        .clk              (clk),
        .reset            (reset),
        .inicio           (inicio),
        .tamano_mascara   (tamano_mascara),
        .desplazamiento   (desplazamiento),
        .dato_valido      (dato_valido),
        .pixel            (pixel),
        .coeficiente      (coeficiente),
        .indice_mascara   (indice_mascara),
        .ocupado          (ocupado),
        .resultado        (resultado),
        .resultado_valido (resultado_valido),
        .error_tamano     (error_tamano)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One complete window; samples come from pixs/coefs.
    task automatic run_window(input int n, input int sh, input int gap_max,
                              input bit spam, input int exp, input string name);
        int total;
        int g;
        total = n * n;
        inicio = 1'b1;
        tamano_mascara = n[3:0];
        desplazamiento = sh[3:0];
        tick();
        inicio = 1'b0;
        check({name, " ocupado tras inicio"}, ocupado, 1);
        for (int k = 0; k < total; k++) begin
            g = (gap_max > 0) ? (k % (gap_max + 1)) : 0;
            for (int j = 0; j < g; j++) begin
                dato_valido = 1'b0;
                pixel = 8'hFF;
                coeficiente = 8'h7F;
                if (spam) begin
                    inicio = 1'b1;
                    tamano_mascara = 4'd1;
                end
                tick();
                inicio = 1'b0;
                check({name, " indice en hueco"}, indice_mascara, k);
                if (spam) check({name, " error_tamano en hueco"}, error_tamano, 0);
            end
            check({name, " indice"}, indice_mascara, k);
            dato_valido = 1'b1;
            pixel = pixs[k][7:0];
            coeficiente = coefs[k][7:0];
            tick();
            dato_valido = 1'b0;
        end
        check({name, " indice vuelve a 0"}, indice_mascara, 0);
        check({name, " valido t+0"}, resultado_valido, 0);
        tick();
        check({name, " valido t+1"}, resultado_valido, 0);
        tick();
        check({name, " valido t+2"}, resultado_valido, 1);
        check({name, " resultado"}, resultado, exp);
        check({name, " ocupado en pulso"}, ocupado, 1);
        tick();
        check({name, " valido tras pulso"}, resultado_valido, 0);
        check({name, " ocupado tras pulso"}, ocupado, 0);
        check({name, " resultado retenido"}, resultado, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        inicio = 1'b0;
        tamano_mascara = 4'd0;
        desplazamiento = 4'd0;
        dato_valido = 1'b0;
        pixel = 8'd0;
        coeficiente = 8'd0;

        //          n   sh  pix   coef  exp
        tabla[0]  = '{3,  0,  10,    1,  90};
        tabla[1]  = '{3,  3,  255, 127, 255};
        tabla[2]  = '{3,  3,  255,  -1,   0};
        tabla[3]  = '{1,  0,  200,   1, 200};
        tabla[4]  = '{2,  1,  100,  -3,   0};
        tabla[5]  = '{1,  4,  255, 127, 255};
        tabla[6]  = '{2,  4,  16,    1,   4};
        tabla[7]  = '{3,  1,  7,     3,  94};
        tabla[8]  = '{1,  1,  3,    -1,   0};
        tabla[9]  = '{15, 15, 255, 127, 222};
        tabla[10] = '{2,  0,  60,    1, 240};
        tabla[11] = '{2,  0,  64,    1, 255};
        tabla[12] = '{1,  0,  255,   1, 255};
        tabla[13] = '{1,  0,  255, -128,  0};

        tick();
        tick();
        check("reset indice", indice_mascara, 0);
        check("reset ocupado", ocupado, 0);
        check("reset resultado", resultado, 0);
        check("reset valido", resultado_valido, 0);
        check("reset error", error_tamano, 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 14; v++) begin
            for (int k = 0; k < 225; k++) begin
                pixs[k] = tabla[v].pix;
                coefs[k] = tabla[v].coef;
            end
            run_window(tabla[v].n, tabla[v].sh, 0, 1'b0, tabla[v].exp, $sformatf("vec%0d", v));
            tick();
        end

        // Gapped samples with start requests spammed during ACUMULA.
        pixs[0] = 4;  pixs[1] = 8;  pixs[2] = 12; pixs[3] = 16;
        for (int k = 0; k < 4; k++) coefs[k] = 1;
        run_window(2, 2, 3, 1'b1, 10, "huecos");

        // Zero-size start is rejected with a single pulse.
        inicio = 1'b1;
        tamano_mascara = 4'd0;
        tick();
        inicio = 1'b0;
        check("error pulso", error_tamano, 1);
        check("error ocupado", ocupado, 0);
        tick();
        check("error fin pulso", error_tamano, 0);
        check("error ocupado 2", ocupado, 0);

        // Samples while idle are ignored.
        dato_valido = 1'b1;
        pixel = 8'd99;
        coeficiente = 8'd5;
        repeat (3) tick();
        dato_valido = 1'b0;
        check("reposo indice", indice_mascara, 0);
        check("reposo ocupado", ocupado, 0);

        // Mid-window reset with start and data asserted on the same edge.
        inicio = 1'b1;
        tamano_mascara = 4'd3;
        desplazamiento = 4'd0;
        tick();
        inicio = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dato_valido = 1'b1;
            pixel = 8'd100;
            coeficiente = 8'd100;
            tick();
        end
        check("aborto indice previo", indice_mascara, 5);
        reset = 1'b1;
        inicio = 1'b1;
        tamano_mascara = 4'd1;
        tick();
        reset = 1'b0;
        inicio = 1'b0;
        dato_valido = 1'b0;
        check("aborto indice", indice_mascara, 0);
        check("aborto ocupado", ocupado, 0);
        check("aborto resultado", resultado, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("aborto sin pulso", resultado_valido, 0);
            check("aborto sigue libre", ocupado, 0);
        end
        pixs[0] = 200;
        coefs[0] = 1;
        run_window(1, 0, 0, 1'b0, 200, "tras aborto");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
